mipi_csi2_capture_ctrl: RTL and testbench
=========================================

Name: mipi_csi2_capture_ctrl

Overview:
Capture sequencer for the CSI-2 deserializer. Drives the deserializer `enable` and arms capture on a clean frame start. It gates the deserializer `fvo`/`lvo`/`dvo`/`dato` so only whole frames pass downstream. It also runs single-shot, N-frame or continuous capture, and recovers from stalled links with a watchdog-driven resync. Sits on `img_clk` between `mipi_csi2_des` and the image pipeline, configured by host registers.

Parameters:
- DATA_WIDTH, 8, width of `dat_in`/`dat_out`; matches the deserializer.
- RESYNC_CYCLES, 16, cycles `des_enable` is held low during a resync; minimum 2.
- CNT_WIDTH, 16, width of frame/line/pixel counters.

Ports:
- img_clk  in  1  deserializer output clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  1-cycle pulse: begin capture.
- stop  in  1  1-cycle pulse: end capture after the current frame.
- num_frames  in  CNT_WIDTH  frames per start; 0 = continuous; sampled on accepted start.
- timeout  in  CNT_WIDTH  watchdog limit in cycles; 0 disables the watchdog.
- des_enable  out  1  drives deserializer `enable`.
- fv_in, lv_in, dv_in  in  1 each  deserializer `fvo`, `lvo`, `dvo`.
- dat_in  in  DATA_WIDTH  deserializer `dato`.
- fv_out, lv_out, dv_out  out  1 each  gated frame/line/data valid.
- dat_out  out  DATA_WIDTH  registered copy of `dat_in`.
- busy  out  1  state != IDLE.
- frame_done  out  1  pulse per completed frame.
- frame_abort  out  1  pulse when the watchdog kills a frame in progress.
- frame_cnt  out  CNT_WIDTH  completed frames since reset; wraps.
- timeout_cnt  out  8  watchdog events since reset; saturates at 255.
- exp_lines, exp_ppl  in  CNT_WIDTH each  expected size; 0 = don't check (stats build only).
- last_lines, last_ppl  out  CNT_WIDTH each  measured size of the last completed frame (stats build only).
- size_err  out  1  sticky; cleared on accepted start (stats build only).

Behaviour:
- Reset: every output 0. State = IDLE. Internal `fv_in` delay (`fv_d`) = 0. Stop-pending = 0. Watchdog = 0.
- Edge terms: fs = `fv_in` & !`fv_d`; fe = !`fv_in` & `fv_d`.
- IDLE:
  - `des_enable` = 0.
  - `start` & !`stop` → ARM; load frames_left = `num_frames`; clear stop-pending.
  - `start` & `stop` together: stay in IDLE.
- ARM:
  - `des_enable` = 1; gate closed. A frame already in progress (`fv_in` high on entry) is skipped.
  - fs → CAPTURE.
  - `stop` → IDLE next cycle.
- CAPTURE:
  - `des_enable` = 1; gate open.
  - `stop` sets stop-pending; the current frame completes.
  - On fe: `frame_done` = 1 for one cycle; `frame_cnt` += 1.
    - If stop-pending or frames_left == 1 → IDLE.
    - Otherwise, if frames_left != 0, decrement it; → ARM.
- RESYNC:
  - `des_enable` = 0 for RESYNC_CYCLES cycles, then → ARM.
  - `start`/`stop` ignored, except that `stop` sets stop-pending; ARM then exits to IDLE immediately.
- Watchdog:
  - Counts in ARM and CAPTURE only.
  - Cleared on any cycle with `dv_in`, fs or fe, and on every state entry.
  - Count == `timeout` (`timeout` != 0) → RESYNC; `timeout_cnt` += 1 (saturating).
  - If the watchdog fires in CAPTURE: `frame_abort` pulses; no `frame_done`; `frame_cnt` unchanged; frames_left unchanged.
  - Watchdog has priority over fe in the same cycle.
- Gating, fixed 1-cycle latency:
  - open(t) = (state == CAPTURE & no watchdog fire) | (state == ARM & fs).
  - `fv_out`(t+1) = `fv_in`(t) & open(t); same rule for `lv_out` and `dv_out`.
  - `dat_out`(t+1) = `dat_in`(t), unconditionally.
  - On abort, all valid outputs drop to 0 the cycle after the fire.
- `frame_done` is coincident with `fv_out` falling.
- `reset` mid-frame: all outputs 0 the next cycle, state IDLE.

Optional Feature:
- Macro: MIPI_CAP_STATS_EN.
- Defined:
  - Line counter increments on each `lv_in` rising edge while open.
  - Pixel counter counts `dv_in` while open & `lv_in`; it is cleared on each `lv_in` rising edge.
  - On fe in CAPTURE: latch `last_lines` and `last_ppl` (the last line's count).
  - Set `size_err` if (`exp_lines` != 0 & mismatch) or (`exp_ppl` != 0 & mismatch).
  - Aborted frames latch nothing.
- Undefined: `last_lines`, `last_ppl` and `size_err` tied to 0; `exp_*` inputs unused; no counters synthesized.

Test Plan:
- `num_frames` = 1, `start`, then 3 frames of 4 lines × 10 `dv` → exactly frame 1 gated; `frame_done` ×1; `frame_cnt` = 1; `busy` low after its fe.
- `start` while `fv_in` already high mid-frame, `num_frames` = 2 → partial frame fully blocked (`fv_out` stays 0); next 2 frames passed; `frame_cnt` = 2.
- `num_frames` = 0; `stop` pulsed during line 2 of frame 3 → frame 3 completes fully; `frame_cnt` = 3; IDLE; `des_enable` = 0.
- `timeout` = 50; `fv_in` high, inputs frozen → watchdog fires at count 50; `frame_abort` ×1; `des_enable` low for exactly 16 cycles; `timeout_cnt` = 1; returns to ARM; next full frame completes with `frame_cnt` += 1.
- Stats build: `exp_lines` = 4, `exp_ppl` = 10; send 4×10 frame, then 4×9 frame → first: `last_ppl` = 10, `size_err` = 0; second: `last_ppl` = 9, `size_err` = 1 and stays set; cleared by next `start`.
- Same-cycle `start` & `stop` in IDLE → stays IDLE, `des_enable` = 0; `reset` asserted mid-CAPTURE → all outputs 0 next cycle.

Source files
------------

// File: rtl/mipi_csi2_capture_ctrl.sv
// Capture sequencer between mipi_csi2_des and the image pipeline: arms on a clean frame
// start, gates whole frames, runs N-frame/continuous capture and resyncs stalled links.
// Optional frame-size statistics are built when MIPI_CAP_STATS_EN is defined.
module mipi_csi2_capture_ctrl #(
   parameter int DATA_WIDTH    = 8,
   parameter int RESYNC_CYCLES = 16,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                  img_clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stop,
   input  logic [CNT_WIDTH-1:0]  num_frames,
   input  logic [CNT_WIDTH-1:0]  timeout,
   output logic                  des_enable,
   input  logic                  fv_in,
   input  logic                  lv_in,
   input  logic                  dv_in,
   input  logic [DATA_WIDTH-1:0] dat_in,
   output logic                  fv_out,
   output logic                  lv_out,
   output logic                  dv_out,
   output logic [DATA_WIDTH-1:0] dat_out,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  frame_abort,
   output logic [CNT_WIDTH-1:0]  frame_cnt,
   output logic [7:0]            timeout_cnt,
   input  logic [CNT_WIDTH-1:0]  exp_lines,
   input  logic [CNT_WIDTH-1:0]  exp_ppl,
   output logic [CNT_WIDTH-1:0]  last_lines,
   output logic [CNT_WIDTH-1:0]  last_ppl,
   output logic                  size_err
);

   localparam int RS_W = (RESYNC_CYCLES > 2) ? $clog2(RESYNC_CYCLES) : 1;
   localparam logic [RS_W-1:0] RS_LAST = RS_W'(RESYNC_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ARM, CAPTURE, RESYNC} state_t;

   state_t                 state, state_nxt;
   logic                   fv_d;
   logic                   fs, fe;
   logic [CNT_WIDTH-1:0]   wd_cnt;
   logic                   wd_fire;
   logic [RS_W-1:0]        rs_cnt;
   logic [CNT_WIDTH-1:0]   frames_left;
   logic                   stop_pend;
   logic                   accept_start;
   logic                   gate_open;
   logic                   done_nxt;
   logic                   abort_nxt;

   assign fs           = fv_in & ~fv_d;
   assign fe           = ~fv_in & fv_d;
   assign accept_start = (state == IDLE) & start & ~stop;
   assign wd_fire      = ((state == ARM) | (state == CAPTURE)) & (timeout != '0) & (wd_cnt == timeout);

   always_ff @(posedge img_clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept_start) state_nxt = ARM;
         ARM: begin
            if (wd_fire)                state_nxt = RESYNC;
            else if (stop | stop_pend)  state_nxt = IDLE;
            else if (fs)                state_nxt = CAPTURE;
         end
         CAPTURE: begin
            if (wd_fire) state_nxt = RESYNC;
            else if (fe) begin
               if (stop_pend | stop | (frames_left == CNT_WIDTH'(1))) state_nxt = IDLE;
               else                                                   state_nxt = ARM;
            end
         end
         RESYNC:  if (rs_cnt == RS_LAST) state_nxt = ARM;
         default: state_nxt = IDLE;
      endcase
   end

   // A frame only opens the gate on the fs cycle that actually moves ARM into CAPTURE
   always_comb begin
      des_enable = (state == ARM) | (state == CAPTURE);
      busy       = (state != IDLE);
      gate_open  = ~wd_fire & ((state == CAPTURE) | ((state == ARM) & (state_nxt == CAPTURE)));
      done_nxt   = (state == CAPTURE) & fe & ~wd_fire;
      abort_nxt  = (state == CAPTURE) & wd_fire;
   end

   always_ff @(posedge img_clk) begin
      if (reset) begin
         fv_d        <= 1'b0;
         wd_cnt      <= '0;
         rs_cnt      <= '0;
         frames_left <= '0;
         stop_pend   <= 1'b0;
         frame_cnt   <= '0;
         timeout_cnt <= '0;
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
         fv_out      <= 1'b0;
         lv_out      <= 1'b0;
         dv_out      <= 1'b0;
         dat_out     <= '0;
      end else begin
         fv_d <= fv_in;
         if ((state_nxt != state) | fs | fe | dv_in | ~des_enable) wd_cnt <= '0;
         else                                                      wd_cnt <= wd_cnt + CNT_WIDTH'(1);
         if (state == RESYNC) rs_cnt <= rs_cnt + RS_W'(1);
         else                 rs_cnt <= '0;
         if (accept_start) frames_left <= num_frames;
         else if ((state == CAPTURE) & (state_nxt == ARM) & (frames_left != '0))
            frames_left <= frames_left - CNT_WIDTH'(1);
         if (accept_start)                                     stop_pend <= 1'b0;
         else if (((state == CAPTURE) | (state == RESYNC)) & stop) stop_pend <= 1'b1;
         if (done_nxt)                        frame_cnt   <= frame_cnt + CNT_WIDTH'(1);
         if (wd_fire & (timeout_cnt != 8'hFF)) timeout_cnt <= timeout_cnt + 8'd1;
         frame_done  <= done_nxt;
         frame_abort <= abort_nxt;
         fv_out      <= fv_in & gate_open;
         lv_out      <= lv_in & gate_open;
         dv_out      <= dv_in & gate_open;
         dat_out     <= dat_in;
      end
   end

`ifdef MIPI_CAP_STATS_EN
   logic                 lv_d;
   logic                 lv_rise;
   logic [CNT_WIDTH-1:0] line_cnt;
   logic [CNT_WIDTH-1:0] pix_cnt;

   assign lv_rise = lv_in & ~lv_d;

   // Line count restarts with each frame; pixel count always holds the latest line
   always_ff @(posedge img_clk) begin
      if (reset) begin
         lv_d       <= 1'b0;
         line_cnt   <= '0;
         pix_cnt    <= '0;
         last_lines <= '0;
         last_ppl   <= '0;
         size_err   <= 1'b0;
      end else begin
         lv_d <= lv_in;
         if (gate_open) begin
            line_cnt <= ((state == ARM) ? '0 : line_cnt) + CNT_WIDTH'(lv_rise);
            if (lv_rise)              pix_cnt <= CNT_WIDTH'(dv_in);
            else if (lv_in & dv_in)   pix_cnt <= pix_cnt + CNT_WIDTH'(1);
         end else if (state != CAPTURE) begin
            line_cnt <= '0;
         end
         if (done_nxt) begin
            last_lines <= line_cnt;
            last_ppl   <= pix_cnt;
            if (((exp_lines != '0) & (line_cnt != exp_lines)) | ((exp_ppl != '0) & (pix_cnt != exp_ppl)))
               size_err <= 1'b1;
         end
         if (accept_start) size_err <= 1'b0;
      end
   end
`else
   logic unused_stats;
   assign unused_stats = ^{exp_lines, exp_ppl};
   assign last_lines   = '0;
   assign last_ppl     = '0;
   assign size_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mipi_csi2_capture_ctrl.sv
// Directed bench for mipi_csi2_capture_ctrl: per-cycle vector table plus frame-level sequences.
module tb_mipi_csi2_capture_ctrl;

   logic        img_clk = 1'b0;
   logic        reset;
   logic        start, stop;
   logic [15:0] num_frames, timeout;
   logic        des_enable;
   logic        fv_in, lv_in, dv_in;
   logic [7:0]  dat_in;
   logic        fv_out, lv_out, dv_out;
   logic [7:0]  dat_out;
   logic        busy, frame_done, frame_abort;
   logic [15:0] frame_cnt;
   logic [7:0]  timeout_cnt;
   logic [15:0] exp_lines, exp_ppl, last_lines, last_ppl;
   logic        size_err;

   mipi_csi2_capture_ctrl #(.DATA_WIDTH(8), .RESYNC_CYCLES(16), .CNT_WIDTH(16)) dut (
      .img_clk(img_clk), .reset(reset), .start(start), .stop(stop),
      .num_frames(num_frames), .timeout(timeout), .des_enable(des_enable),
      .fv_in(fv_in), .lv_in(lv_in), .dv_in(dv_in), .dat_in(dat_in),
      .fv_out(fv_out), .lv_out(lv_out), .dv_out(dv_out), .dat_out(dat_out),
      .busy(busy), .frame_done(frame_done), .frame_abort(frame_abort),
      .frame_cnt(frame_cnt), .timeout_cnt(timeout_cnt),
      .exp_lines(exp_lines), .exp_ppl(exp_ppl),
      .last_lines(last_lines), .last_ppl(last_ppl), .size_err(size_err)
   );

   always #5 img_clk = ~img_clk;

   typedef struct {
      logic       start, stop, fv, lv, dv;
      logic [7:0] dat;
      logic [6:0] exp_ctl;   // {fv_out, lv_out, dv_out, busy, des_enable, frame_done, frame_abort}
      logic [7:0] exp_dat;
   } vec_t;

   vec_t vecs[8];

   int n_checks = 0;
   int n_errors = 0;
   int n_done, n_abort, n_dvo, n_fvo;
   logic prev_fvo = 1'b0;
   int exp_fcnt = 0;

   function automatic vec_t mk(input logic st, sp, fv, lv, dv, input logic [7:0] d,
                               input logic [6:0] ec, input logic [7:0] ed);
      vec_t v;
      v.start = st; v.stop = sp; v.fv = fv; v.lv = lv; v.dv = dv; v.dat = d;
      v.exp_ctl = ec; v.exp_dat = ed;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge img_clk);
      #1;
      n_done  += int'(frame_done);
      n_abort += int'(frame_abort);
      n_dvo   += int'(dv_out);
      n_fvo   += int'(fv_out);
      if (frame_done) chk("done_at_fvo_fall", {62'd0, prev_fvo, fv_out}, 64'h2);
      prev_fvo = fv_out;
   endtask

   task automatic clr_counts();
      n_done = 0; n_abort = 0; n_dvo = 0; n_fvo = 0;
   endtask

   task automatic set_idle_inputs();
      start = 0; stop = 0; fv_in = 0; lv_in = 0; dv_in = 0;
   endtask

   // fs cycle, lines of ppl pixels with 2-cycle line gaps, fe, 2 idle cycles
   task automatic send_frame(input int lines, input int ppl, input int stop_line);
      fv_in = 1; lv_in = 0; dv_in = 0;
      tick();
      for (int l = 0; l < lines; l++) begin
         for (int p = 0; p < ppl; p++) begin
            lv_in = 1; dv_in = 1; dat_in = 8'($urandom);
            stop = (l == stop_line) && (p == 0);
            tick();
            stop = 0;
         end
         lv_in = 0; dv_in = 0;
         tick(); tick();
      end
      fv_in = 0;
      tick(); tick(); tick();
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "global timeout");
   end

   initial begin
      int lat, nlow;
      clr_counts();
      set_idle_inputs();
      dat_in = 8'h00; num_frames = 16'd1; timeout = 16'd0; exp_lines = 0; exp_ppl = 0;
      reset = 1;
      tick(); tick();
      chk("reset_ctl", {fv_out, lv_out, dv_out, busy, des_enable, frame_done, frame_abort}, 0);
      chk("reset_cnt", {dat_out, frame_cnt, timeout_cnt, last_lines, last_ppl, size_err}, 0);
      reset = 0;
      tick();

      // Per-cycle table, num_frames = 1
      vecs[0] = mk(1,0,0,0,0, 8'h11, 7'b0001100, 8'h11);
      vecs[1] = mk(0,0,1,0,0, 8'h22, 7'b1001100, 8'h22);
      vecs[2] = mk(0,0,1,1,1, 8'h33, 7'b1111100, 8'h33);
      vecs[3] = mk(0,0,1,1,0, 8'h44, 7'b1101100, 8'h44);
      vecs[4] = mk(0,0,1,0,0, 8'h55, 7'b1001100, 8'h55);
      vecs[5] = mk(0,0,0,0,0, 8'h66, 7'b0000010, 8'h66);
      vecs[6] = mk(0,0,1,1,1, 8'h77, 7'b0000000, 8'h77);
      vecs[7] = mk(0,0,0,0,0, 8'h88, 7'b0000000, 8'h88);
      for (int i = 0; i < 8; i++) begin
         start = vecs[i].start; stop = vecs[i].stop;
         fv_in = vecs[i].fv; lv_in = vecs[i].lv; dv_in = vecs[i].dv; dat_in = vecs[i].dat;
         tick();
         chk($sformatf("vec%0d_ctl", i),
             {fv_out, lv_out, dv_out, busy, des_enable, frame_done, frame_abort}, vecs[i].exp_ctl);
         chk($sformatf("vec%0d_dat", i), dat_out, vecs[i].exp_dat);
      end
      set_idle_inputs();
      exp_fcnt += 1;
      chk("vec_frame_cnt", frame_cnt, exp_fcnt);

      // Single shot: only the first of three frames passes
      clr_counts();
      num_frames = 1; start = 1; tick(); start = 0;
      for (int f = 0; f < 3; f++) send_frame(4, 10, -1);
      exp_fcnt += 1;
      chk("single_done", n_done, 1);
      chk("single_dvo", n_dvo, 40);
      chk("single_fcnt", frame_cnt, exp_fcnt);
      chk("single_busy", busy, 0);

      // Start mid-frame: partial frame blocked, then two frames
      fv_in = 1; lv_in = 1; dv_in = 1; tick();
      num_frames = 2; start = 1; tick(); start = 0;
      clr_counts();
      for (int i = 0; i < 12; i++) tick();
      fv_in = 0; lv_in = 0; dv_in = 0; tick(); tick();
      chk("midframe_blocked_fvo", n_fvo, 0);
      chk("midframe_busy", busy, 1);
      clr_counts();
      for (int f = 0; f < 3; f++) send_frame(4, 10, -1);
      exp_fcnt += 2;
      chk("nframe_done", n_done, 2);
      chk("nframe_dvo", n_dvo, 80);
      chk("nframe_fcnt", frame_cnt, exp_fcnt);

      // Continuous capture, stop during line 2 of frame 3
      clr_counts();
      num_frames = 0; start = 1; tick(); start = 0;
      send_frame(4, 10, -1);
      send_frame(4, 10, -1);
      send_frame(4, 10, 1);
      chk("cont_busy_after_stop", {busy, des_enable}, 0);
      send_frame(4, 10, -1);
      exp_fcnt += 3;
      chk("cont_done", n_done, 3);
      chk("cont_dvo", n_dvo, 120);
      chk("cont_fcnt", frame_cnt, exp_fcnt);

      // Watchdog: stall inside a frame
      clr_counts();
      timeout = 50; num_frames = 0; start = 1; tick(); start = 0;
      fv_in = 1; tick();
      lat = 0;
      while (!frame_abort && lat < 200) begin
         tick();
         lat++;
      end
      chk("wd_latency", lat, 51);
      chk("wd_outputs_dropped", {fv_out, lv_out, dv_out, des_enable}, 0);
      nlow = 1;
      while (!des_enable && nlow < 100) begin
         tick();
         if (!des_enable) nlow++;
      end
      chk("wd_resync_len", nlow, 16);
      chk("wd_tcnt", timeout_cnt, 1);
      chk("wd_abort_cnt", n_abort, 1);
      chk("wd_no_done", n_done, 0);
      chk("wd_fcnt_kept", frame_cnt, exp_fcnt);
      chk("wd_back_in_arm", busy, 1);
      fv_in = 0; tick();
      clr_counts();
      send_frame(4, 10, -1);
      exp_fcnt += 1;
      chk("wd_recover_done", n_done, 1);
      chk("wd_recover_fcnt", frame_cnt, exp_fcnt);
      stop = 1; tick(); stop = 0; tick();
      chk("wd_stop_in_arm", busy, 0);
      timeout = 0;

`ifdef MIPI_CAP_STATS_EN
      exp_lines = 4; exp_ppl = 10; num_frames = 0;
      start = 1; tick(); start = 0;
      send_frame(4, 10, -1);
      chk("stats1", {last_lines, last_ppl, 15'd0, size_err}, {16'd4, 16'd10, 16'd0});
      send_frame(4, 9, -1);
      chk("stats2", {last_lines, last_ppl, 15'd0, size_err}, {16'd4, 16'd9, 16'd1});
      send_frame(4, 10, -1);
      chk("stats_sticky", size_err, 1);
      stop = 1; tick(); stop = 0;
      start = 1; tick(); start = 0;
      chk("stats_clear_on_start", size_err, 0);
      stop = 1; tick(); stop = 0; tick();
      exp_fcnt += 3;
      chk("stats_fcnt", frame_cnt, exp_fcnt);
      exp_lines = 0; exp_ppl = 0;
`else
      chk("stats_tied_off", {last_lines, last_ppl, 15'd0, size_err}, 0);
`endif

      // Simultaneous start and stop in IDLE
      start = 1; stop = 1; tick(); start = 0; stop = 0;
      chk("start_stop_idle", {busy, des_enable}, 0);
      tick();
      chk("start_stop_idle_hold", {busy, des_enable}, 0);

      // Reset in the middle of a captured frame
      num_frames = 0; start = 1; tick(); start = 0;
      fv_in = 1; tick();
      lv_in = 1; dv_in = 1; dat_in = 8'hA5; tick(); tick(); tick();
      chk("pre_reset_capturing", {fv_out, lv_out, dv_out, busy}, 4'hF);
      reset = 1; dat_in = 8'h5A; tick();
      chk("midframe_reset_ctl", {fv_out, lv_out, dv_out, busy, des_enable, frame_done, frame_abort}, 0);
      chk("midframe_reset_cnt", {dat_out, frame_cnt, timeout_cnt}, 0);
      reset = 0; set_idle_inputs(); tick();
      chk("post_reset_idle", {busy, des_enable}, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
